amo_ctrl: RTL and testbench

Cache-side atomic-operation sequencer.
- Accepts one AMO/LR/SC request from the LSU.
- Performs the read-modify-write against the D-cache port: read, compute, write back.
- Returns the rd value to the LSU.
- Tracks a single LR/SC reservation with real SC failure, snoop invalidation and timeout.

---
 rtl/amo_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_amo_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_ctrl.sv
// Atomic-operation sequencer: runs AMO/LR/SC read-modify-write against the D-cache and tracks one LR/SC reservation.
// Latency (zero-wait cache): AMO 6 cycles, LR 3, SC success 4, error or SC failure 1, counted from accept to rsp_valid_o.
// Backpressure: one request in flight; req_ready_o only in IDLE; mem and rsp valids hold with stable payload until accepted.
module amo_ctrl #(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 64,
  parameter int RSV_TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [4:0]        req_funct5_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [XLEN-1:0]   req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [1:0]        mem_size_o,
  output logic              mem_rd_valid_o,
  output logic              mem_wr_valid_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_wack_i,
  input  logic              mem_err_i,
  input  logic              snoop_valid_i,
  input  logic [ADDR_W-1:0] snoop_addr_i
);

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  localparam int TW = $clog2(RSV_TIMEOUT + 1);
  localparam int GW = ADDR_W - 3;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_RWAIT, S_CALC, S_WRITE, S_WWAIT, S_RESP
  } state_t;

  state_t state_q, state_d;

  // Captured request and datapath registers
  logic [4:0]        op_q;
  logic              dw_q;
  logic [XLEN-1:0]   rs2_q;
  logic [XLEN-1:0]   old_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic              rsp_err_q;
  logic [XLEN-1:0]   wdata_q;

  // Reservation
  logic          rsv_vld_q;
  logic [GW-1:0] rsv_gran_q;
  logic [TW-1:0] rsv_tmr_q;

  // Request decode, evaluated on the accept cycle
  logic          acc;
  logic          is_dw;
  logic          f3_ok;
  logic          f5_ok;
  logic          align_ok;
  logic          req_err;
  logic          req_is_sc;
  logic [GW-1:0] req_gran;
  logic [GW-1:0] snoop_gran;
  logic          sc_ok;
  logic          unused_snoop_lsb;

  assign unused_snoop_lsb = ^snoop_addr_i[2:0];

  assign acc        = req_valid_i && (state_q == S_IDLE);
  assign is_dw      = (req_funct3_i == 3'b011);
  assign f3_ok      = (req_funct3_i == 3'b010) || (is_dw && (XLEN >= 64));
  assign align_ok   = is_dw ? (req_addr_i[2:0] == 3'b000) : (req_addr_i[1:0] == 2'b00);
  assign req_err    = !(f3_ok && f5_ok && align_ok);
  assign req_is_sc  = (req_funct5_i == F5_SC);
  assign req_gran   = req_addr_i[ADDR_W-1:3];
  assign snoop_gran = snoop_addr_i[ADDR_W-1:3];
  // A snoop to the SC's own granule in the accept cycle beats the reservation.
  assign sc_ok      = rsv_vld_q && (rsv_gran_q == req_gran) &&
                      !(snoop_valid_i && (snoop_gran == req_gran));

  // Legal funct5 encodings
  always_comb begin
    f5_ok = 1'b0;
    case (req_funct5_i)
      F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR,
      F5_AND, F5_MIN, F5_MAX, F5_MINU, F5_MAXU: f5_ok = 1'b1;
      default:                                  f5_ok = 1'b0;
    endcase
  end

  // Word values returned to rd are sign-extended from bit 31.
  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v[31:0];
    return r;
  endfunction

  // New memory value; word ops only look at [31:0] and write zeros above.
  function automatic logic [XLEN-1:0] amo_result(input logic [4:0] f5, input logic dw,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic [31:0]     a32, b32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    case (f5)
      F5_ADD:  begin r = a + b; r32 = a32 + b32; end
      F5_XOR:  begin r = a ^ b; r32 = a32 ^ b32; end
      F5_OR:   begin r = a | b; r32 = a32 | b32; end
      F5_AND:  begin r = a & b; r32 = a32 & b32; end
      F5_MIN:  begin
        r   = ($signed(a) < $signed(b)) ? a : b;
        r32 = ($signed(a32) < $signed(b32)) ? a32 : b32;
      end
      F5_MAX:  begin
        r   = ($signed(a) > $signed(b)) ? a : b;
        r32 = ($signed(a32) > $signed(b32)) ? a32 : b32;
      end
      F5_MINU: begin r = (a < b) ? a : b; r32 = (a32 < b32) ? a32 : b32; end
      F5_MAXU: begin r = (a > b) ? a : b; r32 = (a32 > b32) ? a32 : b32; end
      default: begin r = b; r32 = b32; end  // SWAP and SC store rs2
    endcase
    if (!dw) begin
      r       = '0;
      r[31:0] = r32;
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (req_err)        state_d = S_RESP;
          else if (req_is_sc) state_d = sc_ok ? S_CALC : S_RESP;
          else                state_d = S_READ;
        end
      end
      S_READ:  if (mem_ready_i) state_d = S_RWAIT;
      S_RWAIT: begin
        if (mem_rvalid_i) begin
          if (mem_err_i || (op_q == F5_LR)) state_d = S_RESP;
          else                              state_d = S_CALC;
        end
      end
      S_CALC:  state_d = S_WRITE;
      S_WRITE: if (mem_ready_i) state_d = S_WWAIT;
      S_WWAIT: if (mem_wack_i)  state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, load data, result and response registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q       <= '0;
      dw_q       <= 1'b0;
      rs2_q      <= '0;
      old_q      <= '0;
      addr_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc) begin
            op_q      <= req_funct5_i;
            dw_q      <= is_dw;
            rs2_q     <= req_data_i;
            addr_q    <= is_dw ? {req_addr_i[ADDR_W-1:3], 3'b000}
                               : {req_addr_i[ADDR_W-1:2], 2'b00};
            rsp_err_q <= req_err;
            // A failed SC reports 1; everything else starts from 0.
            rsp_data_q <= (!req_err && req_is_sc && !sc_ok) ? XLEN'(1) : '0;
          end
        end
        S_RWAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i) begin
              rsp_err_q  <= 1'b1;
              rsp_data_q <= '0;
            end else begin
              old_q      <= mem_rdata_i;
              rsp_data_q <= dw_q ? mem_rdata_i : sext32(mem_rdata_i);
            end
          end
        end
        S_CALC:  wdata_q <= amo_result(op_q, dw_q, old_q, rs2_q);
        S_WWAIT: begin
          if (mem_wack_i && mem_err_i) begin
            rsp_err_q  <= 1'b1;
            rsp_data_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Reservation clear sources other than an LR setting it
  logic rsv_clr;
  logic lr_set;
  assign lr_set  = (state_q == S_RWAIT) && mem_rvalid_i && !mem_err_i && (op_q == F5_LR);
  assign rsv_clr = (snoop_valid_i && (snoop_gran == rsv_gran_q))
                || (rsv_vld_q && (rsv_tmr_q == TW'(RSV_TIMEOUT)))
                || (acc && (req_is_sc || req_err))
                || ((state_q == S_RWAIT) && mem_rvalid_i && mem_err_i)
                || ((state_q == S_WWAIT) && mem_wack_i && mem_err_i)
                || ((state_q == S_WRITE) && mem_ready_i && (op_q != F5_SC)
                    && (addr_q[ADDR_W-1:3] == rsv_gran_q));

  // Reservation tracking; an LR setting it wins over a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsv_vld_q  <= 1'b0;
      rsv_gran_q <= '0;
      rsv_tmr_q  <= '0;
    end else if (lr_set) begin
      rsv_vld_q  <= 1'b1;
      rsv_gran_q <= addr_q[ADDR_W-1:3];
      rsv_tmr_q  <= '0;
    end else if (rsv_clr) begin
      rsv_vld_q <= 1'b0;
      rsv_tmr_q <= '0;
    end else if (rsv_vld_q) begin
      rsv_tmr_q <= rsv_tmr_q + TW'(1);
    end
  end

  assign req_ready_o    = (state_q == S_IDLE);
  assign rsp_valid_o    = (state_q == S_RESP);
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  assign mem_addr_o     = addr_q;
  assign mem_size_o     = dw_q ? 2'b11 : 2'b10;
  assign mem_rd_valid_o = (state_q == S_READ);
  assign mem_wr_valid_o = (state_q == S_WRITE);
  assign mem_wdata_o    = wdata_q;

endmodule

// File: tb/tb_amo_ctrl.sv
// Directed bench for amo_ctrl with a cycle-level cache responder.
// Latency: responses checked against hand-computed cycle counts from accept.
// Backpressure: exercises mem_ready_i stalls and held rsp_ready_i.
module tb_amo_ctrl;
  localparam int XLEN   = 64;
  localparam int ADDR_W = 64;
  localparam int RSV_TO = 1023;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [2:0] F3W    = 3'b010;
  localparam logic [2:0] F3D    = 3'b011;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [4:0]        req_funct5_i;
  logic [2:0]        req_funct3_i;
  logic [XLEN-1:0]   req_data_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [XLEN-1:0]   rsp_data_o;
  logic              rsp_err_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [1:0]        mem_size_o;
  logic              mem_rd_valid_o;
  logic              mem_wr_valid_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_ready_i;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;
  logic              mem_wack_i;
  logic              mem_err_i;
  logic              snoop_valid_i;
  logic [ADDR_W-1:0] snoop_addr_i;

  amo_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RSV_TIMEOUT(RSV_TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_funct5_i(req_funct5_i), .req_funct3_i(req_funct3_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .mem_addr_o(mem_addr_o), .mem_size_o(mem_size_o),
    .mem_rd_valid_o(mem_rd_valid_o), .mem_wr_valid_o(mem_wr_valid_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_wack_i(mem_wack_i), .mem_err_i(mem_err_i),
    .snoop_valid_i(snoop_valid_i), .snoop_addr_i(snoop_addr_i)
  );

  always #5 clk_i = ~clk_i;

  // Responder state and scoreboard counters
  bit          pend_rd, pend_wr, err_rd;
  int          stall;
  logic [63:0] mem_val;
  int          rd_cnt, wr_cnt;
  logic [63:0] last_wdata, last_waddr;
  logic [1:0]  last_wsize;
  int          checks, errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: at the falling edge, return data for last cycle's accepted
  // request and decide mem_ready_i for the coming rising edge.
  task automatic cyc();
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    mem_wack_i   = 1'b0;
    mem_err_i    = 1'b0;
    if (pend_rd) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_val;
      mem_err_i    = err_rd;
      pend_rd      = 1'b0;
    end
    if (pend_wr) begin
      mem_wack_i = 1'b1;
      pend_wr    = 1'b0;
    end
    if ((mem_rd_valid_o || mem_wr_valid_o) && stall > 0) begin
      mem_ready_i = 1'b0;
      stall--;
    end else begin
      mem_ready_i = 1'b1;
    end
    if (mem_rd_valid_o && mem_ready_i) begin
      pend_rd = 1'b1;
      rd_cnt++;
    end
    if (mem_wr_valid_o && mem_ready_i) begin
      pend_wr    = 1'b1;
      wr_cnt++;
      last_wdata = mem_wdata_o;
      last_waddr = mem_addr_o;
      last_wsize = mem_size_o;
    end
  endtask

  // Present a request for exactly the accept edge.
  task automatic send(input logic [4:0] f5, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] d);
    req_funct5_i = f5;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_data_i   = d;
    req_valid_i  = 1'b1;
    cyc();
    req_valid_i  = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid_o && n < 40) begin
      cyc();
      n++;
    end
    if (!rsp_valid_o) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_req(input logic [4:0] f5, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] d,
                        output int lat, output logic [63:0] data, output logic err);
    send(f5, f3, addr, d);
    wait_rsp(lat);
    data = rsp_data_o;
    err  = rsp_err_o;
    cyc();
    chk("b2b_ready", {63'd0, req_ready_o}, 64'd1);
  endtask

  int          lat, r0, w0;
  logic [63:0] d;
  logic        e;
  bit          saw;

  initial begin
    req_valid_i = 0; req_addr_i = '0; req_funct5_i = '0; req_funct3_i = '0;
    req_data_i = '0; rsp_ready_i = 1; mem_ready_i = 1; mem_rvalid_i = 0;
    mem_rdata_i = '0; mem_wack_i = 0; mem_err_i = 0; snoop_valid_i = 0;
    snoop_addr_i = '0; stall = 0; err_rd = 0; mem_val = '0;

    // Reset values
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("rst_rd_valid", {63'd0, mem_rd_valid_o}, 64'd0);
    chk("rst_wr_valid", {63'd0, mem_wr_valid_o}, 64'd0);
    chk("rst_rsp_data", rsp_data_o, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err_o}, 64'd0);
    chk("rst_mem_addr", mem_addr_o, 64'd0);
    chk("rst_wdata", mem_wdata_o, 64'd0);
    rst_i = 1'b1;
    cyc();

    // AMOADD.D
    mem_val = 64'h10; r0 = rd_cnt; w0 = wr_cnt;
    do_req(F_ADD, F3D, 64'h100, 64'h5, lat, d, e);
    chk("add_lat", 64'(lat), 64'd6);
    chk("add_rd", d, 64'h10);
    chk("add_err", {63'd0, e}, 64'd0);
    chk("add_wdata", last_wdata, 64'h15);
    chk("add_waddr", last_waddr, 64'h100);
    chk("add_wsize", {62'd0, last_wsize}, 64'd3);
    chk("add_nrd", 64'(rd_cnt - r0), 64'd1);
    chk("add_nwr", 64'(wr_cnt - w0), 64'd1);

    // AMOMIN.W / AMOMINU.W on the same operands; upper read bits must be ignored
    mem_val = 64'h12345678_FFFFFFFE;
    do_req(F_MIN, F3W, 64'h204, 64'h1, lat, d, e);
    chk("minw_lat", 64'(lat), 64'd6);
    chk("minw_rd", d, 64'hFFFFFFFF_FFFFFFFE);
    chk("minw_wdata", last_wdata, 64'h00000000_FFFFFFFE);
    chk("minw_wsize", {62'd0, last_wsize}, 64'd2);
    do_req(F_MINU, F3W, 64'h204, 64'h1, lat, d, e);
    chk("minuw_rd", d, 64'hFFFFFFFF_FFFFFFFE);
    chk("minuw_wdata", last_wdata, 64'h1);

    // AMOMAX.D signed, AMOXOR.W with rs2 upper bits set
    mem_val = 64'hFFFFFFFF_FFFFFFFF;
    do_req(F_MAX, F3D, 64'h300, 64'h3, lat, d, e);
    chk("maxd_rd", d, 64'hFFFFFFFF_FFFFFFFF);
    chk("maxd_wdata", last_wdata, 64'h3);
    mem_val = 64'hAAAA5555_0F0F0F0F;
    do_req(F_XOR, F3W, 64'h308, 64'hFF00FF00_FFFF0000, lat, d, e);
    chk("xorw_rd", d, 64'h00000000_0F0F0F0F);
    chk("xorw_wdata", last_wdata, 64'h00000000_F0F00F0F);

    // LR.D then SC.D succeeds, second SC.D fails
    mem_val = 64'hDEAD; w0 = wr_cnt;
    do_req(F_LR, F3D, 64'h1000, 64'h0, lat, d, e);
    chk("lr_lat", 64'(lat), 64'd3);
    chk("lr_rd", d, 64'hDEAD);
    chk("lr_nwr", 64'(wr_cnt - w0), 64'd0);
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(F_SC, F3D, 64'h1000, 64'hAB, lat, d, e);
    chk("sc_rd", d, 64'h0);
    chk("sc_err", {63'd0, e}, 64'd0);
    chk("sc_wdata", last_wdata, 64'hAB);
    chk("sc_waddr", last_waddr, 64'h1000);
    chk("sc_nwr", 64'(wr_cnt - w0), 64'd1);
    chk("sc_nrd", 64'(rd_cnt - r0), 64'd0);
    w0 = wr_cnt;
    do_req(F_SC, F3D, 64'h1000, 64'hAB, lat, d, e);
    chk("sc2_lat", 64'(lat), 64'd1);
    chk("sc2_rd", d, 64'h1);
    chk("sc2_nwr", 64'(wr_cnt - w0), 64'd0);

    // Snoop to the reserved granule kills the reservation
    do_req(F_LR, F3D, 64'h2000, 64'h0, lat, d, e);
    snoop_valid_i = 1'b1; snoop_addr_i = 64'h2004;
    cyc();
    snoop_valid_i = 1'b0;
    w0 = wr_cnt;
    do_req(F_SC, F3D, 64'h2000, 64'h77, lat, d, e);
    chk("snoop_sc_rd", d, 64'h1);
    chk("snoop_sc_nwr", 64'(wr_cnt - w0), 64'd0);

    // An AMO write to the reserved granule kills the reservation
    do_req(F_LR, F3D, 64'h5000, 64'h0, lat, d, e);
    do_req(F_ADD, F3D, 64'h5000, 64'h1, lat, d, e);
    do_req(F_SC, F3D, 64'h5000, 64'h9, lat, d, e);
    chk("amo_sc_rd", d, 64'h1);

    // Reservation times out
    do_req(F_LR, F3D, 64'h2000, 64'h0, lat, d, e);
    repeat (RSV_TO + 1) cyc();
    w0 = wr_cnt;
    do_req(F_SC, F3D, 64'h2000, 64'h77, lat, d, e);
    chk("tmo_sc_rd", d, 64'h1);
    chk("tmo_sc_nwr", 64'(wr_cnt - w0), 64'd0);

    // LR.W sign-extends
    mem_val = 64'h00000000_80000000;
    do_req(F_LR, F3W, 64'h3000, 64'h0, lat, d, e);
    chk("lrw_rd", d, 64'hFFFFFFFF_80000000);

    // Request-time errors
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(F_SWAP, F3W, 64'h1002, 64'h1, lat, d, e);
    chk("mis_lat", 64'(lat), 64'd1);
    chk("mis_err", {63'd0, e}, 64'd1);
    chk("mis_rd", d, 64'h0);
    do_req(F_ADD, 3'b000, 64'h100, 64'h1, lat, d, e);
    chk("f3_err", {63'd0, e}, 64'd1);
    do_req(5'b00101, F3D, 64'h100, 64'h1, lat, d, e);
    chk("f5_err", {63'd0, e}, 64'd1);
    do_req(F_ADD, F3D, 64'h104, 64'h1, lat, d, e);
    chk("misd_err", {63'd0, e}, 64'd1);
    chk("err_nmem", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);

    // Read stall, bus error on read data, held response
    stall = 3; err_rd = 1'b1; rsp_ready_i = 1'b0; w0 = wr_cnt;
    send(F_ADD, F3D, 64'h400, 64'h1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_rd_valid", {63'd0, mem_rd_valid_o}, 64'd1);
      chk("stall_addr", mem_addr_o, 64'h400);
      cyc();
    end
    wait_rsp(lat);
    chk("berr_err", {63'd0, rsp_err_o}, 64'd1);
    chk("berr_rd", rsp_data_o, 64'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("hold_valid", {63'd0, rsp_valid_o}, 64'd1);
      chk("hold_err", {63'd0, rsp_err_o}, 64'd1);
      chk("hold_rd", rsp_data_o, 64'h0);
    end
    rsp_ready_i = 1'b1; err_rd = 1'b0;
    cyc();
    chk("berr_ready", {63'd0, req_ready_o}, 64'd1);
    chk("berr_nwr", 64'(wr_cnt - w0), 64'd0);

    // Reset asserted while waiting for the write ack
    mem_val = 64'h1;
    send(F_ADD, F3D, 64'h600, 64'h1);
    repeat (3) cyc();
    chk("pre_rst_wr", {63'd0, mem_wr_valid_o}, 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("mrst_rd_valid", {63'd0, mem_rd_valid_o}, 64'd0);
    chk("mrst_wr_valid", {63'd0, mem_wr_valid_o}, 64'd0);
    chk("mrst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("mrst_req_ready", {63'd0, req_ready_o}, 64'd1);
    chk("mrst_rsp_data", rsp_data_o, 64'h0);
    pend_rd = 1'b0; pend_wr = 1'b0;
    @(negedge clk_i);
    mem_wack_i = 1'b0; mem_rvalid_i = 1'b0;
    rst_i = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      saw = saw | rsp_valid_o;
    end
    chk("no_partial_rsp", {63'd0, saw}, 64'd0);
    mem_val = 64'h7;
    do_req(F_ADD, F3D, 64'h700, 64'h1, lat, d, e);
    chk("recover_lat", 64'(lat), 64'd6);
    chk("recover_wdata", last_wdata, 64'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
